// File: rtl/reset_sequencer.sv
// Ordered reset release for DOMAINS downstream reset domains.
// Domain k leaves reset delay[k]+1 edges after domain k-1 (or after the sequence restarts).
module reset_sequencer #(
    parameter int DOMAINS     = 4,
    parameter int DELAY_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DOMAINS*DELAY_WIDTH-1:0] delay_cfg,
    input  logic                           global_req,
    input  logic [DOMAINS-1:0]             domain_req,
    output logic [DOMAINS-1:0]             domain_rst,
    output logic                           busy,
    output logic                           done
);

    localparam int IDX_W = $clog2(DOMAINS);

    typedef enum logic {
        ST_SEQ  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [DELAY_WIDTH-1:0]         cnt_q, cnt_d;
    logic [DOMAINS*DELAY_WIDTH-1:0] delay_q, delay_d;
    logic [DOMAINS-1:0]             rst_q, rst_d;

    logic                   req_hit;
    logic [IDX_W-1:0]       req_idx;
    logic                   req_restart;
    logic [DELAY_WIDTH-1:0] cur_delay;
    logic [DOMAINS-1:0]     restart_mask;
    logic [DOMAINS-1:0]     release_mask;

    // Lowest requested domain wins; masks select the domains affected by idx/req_idx.
    always_comb begin
        req_hit      = 1'b0;
        req_idx      = '0;
        cur_delay    = '0;
        restart_mask = '0;
        release_mask = '0;
        for (int k = DOMAINS - 1; k >= 0; k--) begin
            if (domain_req[k]) begin
                req_hit = 1'b1;
                req_idx = IDX_W'(k);
            end
        end
        for (int k = 0; k < DOMAINS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_delay = delay_q[k*DELAY_WIDTH +: DELAY_WIDTH];
            end
            restart_mask[k] = (IDX_W'(k) >= req_idx);
            release_mask[k] = (idx_q == IDX_W'(k));
        end
    end

    // A domain request only matters if it targets a domain that is already released.
    assign req_restart = req_hit && ((state_q == ST_DONE) || (req_idx < idx_q));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        delay_d = delay_q;
        rst_d   = rst_q;
        if (global_req) begin
            state_d = ST_SEQ;
            idx_d   = '0;
            cnt_d   = '0;
            delay_d = delay_cfg;
            rst_d   = '1;
        end else if (req_restart) begin
            state_d = ST_SEQ;
            idx_d   = req_idx;
            cnt_d   = '0;
            delay_d = delay_cfg;
            rst_d   = rst_q | restart_mask;
        end else if (state_q == ST_SEQ) begin
            if (cnt_q == cur_delay) begin
                rst_d = rst_q & ~release_mask;
                cnt_d = '0;
                if (idx_q == IDX_W'(DOMAINS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                cnt_d = cnt_q + DELAY_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_SEQ;
            idx_q   <= '0;
            cnt_q   <= '0;
            delay_q <= delay_cfg;
            rst_q   <= '1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            rst_q   <= rst_d;
        end
    end

    assign domain_rst = rst_q;
    assign busy       = |rst_q;
    assign done       = ~(|rst_q);

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed literal checks plus randomized traffic
// compared every cycle against a countdown-schedule model of the release order.
module tb_reset_sequencer;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] delay_cfg;
    logic            global_req;
    logic [N-1:0]    domain_req;
    logic [N-1:0]    domain_rst;
    logic            busy;
    logic            done;

    int n_vec = 0;
    int n_err = 0;

    reset_sequencer #(.DOMAINS(N), .DELAY_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .delay_cfg (delay_cfg),
        .global_req(global_req),
        .domain_req(domain_req),
        .domain_rst(domain_rst),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // m_next = first domain still held (N when all released),
    // m_wait = edges left until m_next is released.
    logic [N-1:0] m_rst;
    int           m_dly[N];
    int           m_next;
    int           m_wait;
    int           m_j;
    bit           m_valid = 1'b0;

    function automatic int lowest_req(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[k]) return k;
        end
        return N;
    endfunction

    always @(posedge clk) begin
        m_j = -1;
        if (!rst_n) begin
            m_j     = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (global_req) begin
                m_j = 0;
            end else if (lowest_req(domain_req) < m_next) begin
                m_j = lowest_req(domain_req);
            end
        end
        if (m_j >= 0) begin
            for (int k = 0; k < N; k++) begin
                m_dly[k] = int'(delay_cfg[k*DW +: DW]);
                if (k >= m_j) m_rst[k] = 1'b1;
            end
            m_next = m_j;
            m_wait = m_dly[m_j] + 1;
        end else if (m_valid && m_next < N) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_rst[m_next] = 1'b0;
                m_next = m_next + 1;
                if (m_next < N) m_wait = m_dly[m_next] + 1;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            n_vec = n_vec + 3;
            if (domain_rst !== m_rst) begin
                n_err++;
                $display("FAIL model_rst t=%0t got=%b exp=%b", $time, domain_rst, m_rst);
            end
            if (busy !== (|m_rst)) begin
                n_err++;
                $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, |m_rst);
            end
            if (done !== ~(|m_rst)) begin
                n_err++;
                $display("FAIL model_done t=%0t got=%b exp=%b", $time, done, ~(|m_rst));
            end
            for (int k = 0; k < N - 1; k++) begin
                n_vec++;
                if (domain_rst[k] && !domain_rst[k+1]) begin
                    n_err++;
                    $display("FAIL thermometer t=%0t got=%b exp=thermometer", $time, domain_rst);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [N-1:0] exp);
        n_vec++;
        if (domain_rst !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b", name, domain_rst, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] dly(input int d0, input int d1, input int d2, input int d3);
        return {d3[DW-1:0], d2[DW-1:0], d1[DW-1:0], d0[DW-1:0]};
    endfunction

    // ---------------- stimulus ----------------
    logic [N-1:0] exp1[1:12];
    int           r;

    initial begin
        exp1[1]  = 4'b1111; exp1[2]  = 4'b1111; exp1[3]  = 4'b1110; exp1[4]  = 4'b1100;
        exp1[5]  = 4'b1100; exp1[6]  = 4'b1100; exp1[7]  = 4'b1100; exp1[8]  = 4'b1100;
        exp1[9]  = 4'b1100; exp1[10] = 4'b1000; exp1[11] = 4'b1000; exp1[12] = 4'b0000;

        rst_n      = 1'b0;
        global_req = 1'b0;
        domain_req = '0;
        delay_cfg  = dly(2, 0, 5, 1);
        repeat (3) tick();
        chk("reset_state", 4'b1111);
        chk_bit("reset_busy", busy, 1'b1);
        chk_bit("reset_done", done, 1'b0);

        // Ordered release with mixed gaps
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk($sformatf("t1_edge%0d", e), exp1[e]);
        end
        chk_bit("t1_done", done, 1'b1);

        // Partial restart from DONE
        delay_cfg = dly(2, 0, 3, 0);
        repeat (2) tick();
        domain_req = 4'b0100;
        tick();
        domain_req = '0;
        chk("t3_req", 4'b1100);
        repeat (3) tick();
        chk("t3_hold", 4'b1100);
        tick();
        chk("t3_bit2", 4'b1000);
        tick();
        chk("t3_bit3", 4'b0000);

        // rst_n in DONE, then all-zero gaps
        delay_cfg = dly(0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_in_done", 4'b1111);
        rst_n = 1'b1;
        tick(); chk("t2_edge1", 4'b1110);
        tick(); chk("t2_edge2", 4'b1100);
        tick(); chk("t2_edge3", 4'b1000);
        chk_bit("t2_busy_edge3", busy, 1'b1);
        tick(); chk("t2_edge4", 4'b0000);
        chk_bit("t2_busy_edge4", busy, 1'b0);

        // Ignored request at idx=2, plus a mid-sequence delay_cfg change
        delay_cfg  = dly(2, 0, 5, 1);
        global_req = 1'b1;
        tick();
        global_req = 1'b0;
        chk("t4_global", 4'b1111);
        for (int e = 1; e <= 12; e++) begin
            if (e == 5) delay_cfg = dly(7, 7, 7, 7);
            if (e == 6) domain_req = 4'b1000;
            tick();
            domain_req = '0;
            chk($sformatf("t4_ignored_edge%0d", e), exp1[e]);
        end

        // Request below idx restarts from domain 0
        delay_cfg  = dly(2, 0, 5, 1);
        global_req = 1'b1;
        tick();
        global_req = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            if (e == 6) domain_req = 4'b0001;
            tick();
            domain_req = '0;
        end
        chk("t4_restart", 4'b1111);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("t4_rerun_edge%0d", e), exp1[e]);
        end

        // Global request on the edge that would release domain 1
        delay_cfg  = dly(1, 1, 1, 1);
        global_req = 1'b1;
        tick();
        global_req = 1'b0;
        chk("t5_global_wins", 4'b1111);
        tick(); chk("t5_new_edge1", 4'b1111);
        tick(); chk("t5_new_edge2", 4'b1110);

        // rst_n during SEQ
        tick();
        rst_n = 1'b0;
        tick();
        chk("t6_rst_in_seq", 4'b1111);
        rst_n = 1'b1;

        // Largest gap: 2^DW edges
        delay_cfg = dly(255, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (255) tick();
        chk("max_gap_edge255", 4'b1111);
        tick();
        chk("max_gap_edge256", 4'b1110);
        repeat (3) tick();
        chk("max_gap_done", 4'b0000);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst_n = 1'b0;
            end else if (r < 5) begin
                global_req = 1'b1;
            end else if (r < 14) begin
                domain_req = N'($urandom_range(1, (1 << N) - 1));
            end
            if ($urandom_range(0, 19) == 0) begin
                delay_cfg = dly($urandom_range(0, 4), $urandom_range(0, 4),
                                $urandom_range(0, 4), $urandom_range(0, 4));
            end
            tick();
            rst_n      = 1'b1;
            global_req = 1'b0;
            domain_req = '0;
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
